// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the WISC instruction-fetch slice.
// Used by fetch_ctrl and fetch_skid_buf.
package fetch_pkg;

  localparam int          FETCH_ADDR_W     = 16;
  localparam int          FETCH_INSTR_W    = 16;
  localparam logic [15:0] PC_INC           = 16'd2;
  localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

  // RUN: normal fetch. KILL: outstanding request is stale, drop its data.
  // DRAIN: like KILL but halts afterwards. HALTED: only reset leaves.
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_KILL   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_e;

  // Saturating 16-bit increment for the optional event counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: output register toward decode plus one skid entry.
// The skid only fills when an instruction arrives while the output register
// is held by a stall; it drains into the output register on the next consume.
module fetch_skid_buf import fetch_pkg::*; #(
  parameter int ADDR_W  = FETCH_ADDR_W,
  parameter int INSTR_W = FETCH_INSTR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_i,
  input  logic               ready_i,
  input  logic               load_i,
  input  logic [INSTR_W-1:0] load_instr_i,
  input  logic [ADDR_W-1:0]  load_pc_i,
  input  logic [ADDR_W-1:0]  load_pc_plus2_i,
  output logic               out_valid_o,
  output logic [INSTR_W-1:0] out_instr_o,
  output logic [ADDR_W-1:0]  out_pc_o,
  output logic [ADDR_W-1:0]  out_pc_plus2_o,
  output logic               skid_valid_next_o
);

  logic               out_valid_q, out_valid_d;
  logic [INSTR_W-1:0] out_instr_q, out_instr_d;
  logic [ADDR_W-1:0]  out_pc_q, out_pc_d;
  logic [ADDR_W-1:0]  out_pc2_q, out_pc2_d;
  logic               skid_valid_q, skid_valid_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic [ADDR_W-1:0]  skid_pc_q, skid_pc_d;
  logic [ADDR_W-1:0]  skid_pc2_q, skid_pc2_d;
  logic               take;

  // Next-state of both entries: flush, skid->output shift, or fresh load.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    out_pc2_d    = out_pc2_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_pc2_d   = skid_pc2_q;
    take         = out_valid_q & ready_i;

    if (flush_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // Skid full implies output full; while held, the request gating
      // guarantees no load can arrive.
      if (take) begin
        out_valid_d  = 1'b1;
        out_instr_d  = skid_instr_q;
        out_pc_d     = skid_pc_q;
        out_pc2_d    = skid_pc2_q;
        skid_valid_d = load_i;
        if (load_i) begin
          skid_instr_d = load_instr_i;
          skid_pc_d    = load_pc_i;
          skid_pc2_d   = load_pc_plus2_i;
        end
      end
    end else if (!out_valid_q || take) begin
      out_valid_d = load_i;
      if (load_i) begin
        out_instr_d = load_instr_i;
        out_pc_d    = load_pc_i;
        out_pc2_d   = load_pc_plus2_i;
      end
    end else if (load_i) begin
      skid_valid_d = 1'b1;
      skid_instr_d = load_instr_i;
      skid_pc_d    = load_pc_i;
      skid_pc2_d   = load_pc_plus2_i;
    end
  end

  // Buffer registers, cleared to zero on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
      out_pc_q     <= '0;
      out_pc2_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      skid_pc2_q   <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      out_pc2_q    <= out_pc2_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_pc2_q   <= skid_pc2_d;
    end
  end

  assign out_valid_o       = out_valid_q;
  assign out_instr_o       = out_instr_q;
  assign out_pc_o          = out_pc_q;
  assign out_pc_plus2_o    = out_pc2_q;
  assign skid_valid_next_o = skid_valid_d;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: WISC instruction-fetch sequencer. Owns the PC, runs the
// single-outstanding imem req/ack handshake and handles redirect/halt.
// Optional macro FETCH_PERF_EN adds saturating fetch/stall/flush counters.
module fetch_ctrl import fetch_pkg::*; #(
  parameter int                ADDR_W   = FETCH_ADDR_W,
  parameter int                INSTR_W  = FETCH_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_in,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt_in,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [ADDR_W-1:0]  if_pc_plus2,
  output logic               halted
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]        perf_fetch_cnt,
  output logic [15:0]        perf_stall_cnt,
  output logic [15:0]        perf_flush_cnt
`endif
);

  localparam logic [ADDR_W-1:0] INC        = ADDR_W'(PC_INC);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-1){1'b1}}, 1'b0};

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic              ack_seen;
  logic              pending;
  logic              redirect_take;
  logic              accept;
  logic [ADDR_W-1:0] pc_plus2;
  logic              skid_valid_next;

  assign ack_seen      = req_q & imem_ack;
  assign pending       = req_q & ~imem_ack;
  assign redirect_take = redirect_valid & (state_q != ST_HALTED);
  assign accept        = ack_seen & (state_q == ST_RUN) & ~redirect_valid & ~halt_in;
  assign pc_plus2      = pc_q + INC;

  fetch_skid_buf #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_skid (
    .clk               (clk),
    .rst_n             (rst_n),
    .flush_i           (redirect_take),
    .ready_i           (~stall_in),
    .load_i            (accept),
    .load_instr_i      (imem_rdata),
    .load_pc_i         (pc_q),
    .load_pc_plus2_i   (pc_plus2),
    .out_valid_o       (if_valid),
    .out_instr_o       (if_instr),
    .out_pc_o          (if_pc),
    .out_pc_plus2_o    (if_pc_plus2),
    .skid_valid_next_o (skid_valid_next)
  );

  // Next state, next PC and next request; redirect outranks halt.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    addr_d  = addr_q;

    if (redirect_take) begin
      pc_d    = redirect_pc & ALIGN_MASK;
      state_d = pending ? ST_KILL : ST_RUN;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (halt_in) begin
            state_d = pending ? ST_DRAIN : ST_HALTED;
          end else if (accept) begin
            pc_d = pc_plus2;
          end
        end
        ST_KILL:   if (ack_seen) state_d = ST_RUN;
        ST_DRAIN:  if (ack_seen) state_d = ST_HALTED;
        ST_HALTED: state_d = ST_HALTED;
        default:   state_d = ST_RUN;
      endcase
    end

    // A request holds until acked; a new one needs a free skid slot.
    if (!pending) begin
      req_d  = (state_d == ST_RUN) && !skid_valid_next;
      addr_d = pc_d;
    end
  end

  // State, PC and request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign halted    = (state_q == ST_HALTED);

`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetch_q;
  logic [15:0] perf_stall_q;
  logic [15:0] perf_flush_q;

  // Saturating event counters: accepted acks, held outputs, redirects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (accept)              perf_fetch_q <= sat_inc16(perf_fetch_q);
      if (if_valid & stall_in) perf_stall_q <= sat_inc16(perf_stall_q);
      if (redirect_take)       perf_flush_q <= sat_inc16(perf_flush_q);
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: scoreboard bench for fetch_ctrl. Expected deliveries are
// queued by the stimulus; a monitor pops one per consumed instruction.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall_in = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        halt_in = 1'b0;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic [15:0] if_pc_plus2;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetch_cnt;
  logic [15:0] perf_stall_cnt;
  logic [15:0] perf_flush_cnt;
`endif

  fetch_ctrl #(
    .ADDR_W   (16),
    .INSTR_W  (16),
    .RESET_PC (16'h0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_in       (stall_in),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_in        (halt_in),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus2    (if_pc_plus2),
    .halted         (halted)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   ack_lat = 0;
  int   ack_budget = 0;
  int   wait_cnt = 0;

  // Memory contents: word at address a is a ^ C3C3.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'hC3C3;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic push(input logic [15:0] pc, input logic [15:0] instr);
    exp_t e;
    e.pc    = pc;
    e.instr = instr;
    exp_q.push_back(e);
  endtask

  // Advance until a request for address a is on the bus (bounded).
  task automatic wait_req(input logic [15:0] a, input string name);
    int k;
    k = 0;
    while (!(imem_req === 1'b1 && imem_addr === a) && k < 40) begin
      cyc();
      k++;
    end
    chk(name, {31'd0, (imem_req === 1'b1 && imem_addr === a)}, 32'd1);
  endtask

  // Memory responder: acks after ack_lat waiting cycles, limited by ack_budget.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && imem_req && ack_budget > 0 && wait_cnt >= ack_lat) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        wait_cnt   = 0;
        ack_budget--;
      end else begin
        imem_ack = 1'b0;
        if (!imem_req) wait_cnt = 0;
        else if (ack_budget > 0) wait_cnt++;
      end
    end
  end

  // Monitor: every consumed instruction must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && if_valid && !stall_in) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got pc=%h instr=%h, required no delivery", if_pc, if_instr);
      end else begin
        mon_e = exp_q.pop_front();
        if (if_pc !== mon_e.pc || if_instr !== mon_e.instr || if_pc_plus2 !== mon_e.pc + 16'd2) begin
          n_err++;
          $display("FAIL sb_delivery: got pc=%h instr=%h pc2=%h, required pc=%h instr=%h pc2=%h",
                   if_pc, if_instr, if_pc_plus2, mon_e.pc, mon_e.instr, mon_e.pc + 16'd2);
        end else begin
          $display("deliver pc=%h instr=%h", if_pc, if_instr);
        end
      end
    end
  end

  initial begin
    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_req",    {31'd0, imem_req}, 32'd0);
    chk("rst_addr",   {16'd0, imem_addr}, 32'h0000);
    chk("rst_valid",  {31'd0, if_valid}, 32'd0);
    chk("rst_instr",  {16'd0, if_instr}, 32'h0000);
    chk("rst_pc",     {16'd0, if_pc}, 32'h0000);
    chk("rst_pc2",    {16'd0, if_pc_plus2}, 32'h0000);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    cyc();
    cyc();

    // Back-to-back fetch with single-cycle acks, then stall into the skid
    push(16'h0000, 16'hC3C3);
    push(16'h0002, 16'hC3C1);
    push(16'h0004, 16'hC3C7);
    ack_lat    = 0;
    ack_budget = 1000;
    rst_n      = 1'b1;
    cyc();
    chk("bb_req0",   {31'd0, imem_req}, 32'd1);
    chk("bb_addr0",  {16'd0, imem_addr}, 32'h0000);
    chk("bb_valid0", {31'd0, if_valid}, 32'd0);
    cyc();
    chk("bb_addr1",  {16'd0, imem_addr}, 32'h0002);
    chk("bb_valid1", {31'd0, if_valid}, 32'd1);
    chk("bb_pc1",    {16'd0, if_pc}, 32'h0000);
    chk("bb_pc2_1",  {16'd0, if_pc_plus2}, 32'h0002);
    cyc();
    chk("bb_addr2",  {16'd0, imem_addr}, 32'h0004);
    chk("bb_pc2",    {16'd0, if_pc}, 32'h0002);
    stall_in = 1'b1;
    cyc();
    chk("skid_req_off", {31'd0, imem_req}, 32'd0);
    chk("skid_hold_pc", {16'd0, if_pc}, 32'h0002);
    cyc();
    chk("skid_req_off2", {31'd0, imem_req}, 32'd0);
    stall_in   = 1'b0;
    ack_budget = 0;
    cyc();
    chk("skid_drain_pc", {16'd0, if_pc}, 32'h0004);
    chk("skid_rereq",    {16'd0, imem_addr}, 32'h0006);
    cyc();
    chk("skid_empty", {31'd0, if_valid}, 32'd0);

    // Redirect while a stale request is outstanding
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0010;
    cyc();
    redirect_valid = 1'b0;
    chk("kill_hold_addr", {16'd0, imem_addr}, 32'h0006);
    chk("kill_valid",     {31'd0, if_valid}, 32'd0);
    push(16'h0040, 16'hC383);
    ack_lat    = 2;
    ack_budget = 1000;
    wait_req(16'h0010, "redir_req_0010");
    cyc();
    chk("redir_addr_c2", {16'd0, imem_addr}, 32'h0010);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0041;
    cyc();
    redirect_valid = 1'b0;
    chk("redir_hold_req",  {31'd0, imem_req}, 32'd1);
    chk("redir_hold_addr", {16'd0, imem_addr}, 32'h0010);
    chk("redir_valid0",    {31'd0, if_valid}, 32'd0);
    cyc();
    chk("redir_new_addr", {16'd0, imem_addr}, 32'h0040);
    chk("redir_valid1",   {31'd0, if_valid}, 32'd0);

    // Halt with a request outstanding
    wait_req(16'h0042, "halt_req_0042");
    halt_in = 1'b1;
    cyc();
    halt_in = 1'b0;
    chk("drain_halted0", {31'd0, halted}, 32'd0);
    chk("drain_addr",    {16'd0, imem_addr}, 32'h0042);
    cyc();
    chk("drain_req", {31'd0, imem_req}, 32'd1);
    cyc();
    chk("halt_halted", {31'd0, halted}, 32'd1);
    chk("halt_req",    {31'd0, imem_req}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0100;
    cyc();
    redirect_valid = 1'b0;
    cyc();
    cyc();
    chk("halt_ignore_redir", {31'd0, imem_req}, 32'd0);
    chk("halt_stays",        {31'd0, halted}, 32'd1);

    // Halt and redirect together: redirect wins
    rst_n = 1'b0;
    #1;
    chk("rst_clears_halt", {31'd0, halted}, 32'd0);
    push(16'h0000, 16'hC3C3);
    push(16'h0080, 16'hC343);
    ack_lat    = 2;
    ack_budget = 1000;
    cyc();
    rst_n = 1'b1;
    wait_req(16'h0002, "hr_req_0002");
    halt_in        = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0081;
    cyc();
    halt_in        = 1'b0;
    redirect_valid = 1'b0;
    chk("hr_not_halted", {31'd0, halted}, 32'd0);
    chk("hr_hold_addr",  {16'd0, imem_addr}, 32'h0002);
    chk("hr_flushed",    {31'd0, if_valid}, 32'd0);
    wait_req(16'h0080, "hr_req_0080");
    wait_req(16'h0082, "hr_req_0082");
    ack_budget = 0;
    chk("hr_still_run", {31'd0, halted}, 32'd0);

    // PC wrap at FFFE
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFE;
    cyc();
    redirect_valid = 1'b0;
    push(16'hFFFE, 16'h3C3D);
    ack_lat    = 0;
    ack_budget = 1000;
    wait_req(16'hFFFE, "wrap_req_fffe");
    cyc();
    ack_budget = 0;
    chk("wrap_valid", {31'd0, if_valid}, 32'd1);
    chk("wrap_pc",    {16'd0, if_pc}, 32'hFFFE);
    chk("wrap_pc2",   {16'd0, if_pc_plus2}, 32'h0000);
    chk("wrap_addr",  {16'd0, imem_addr}, 32'h0000);
    cyc();
    cyc();
    chk("sb_drained", exp_q.size(), 32'd0);

`ifdef FETCH_PERF_EN
    // Event counters: 3 fetches, 2 stall cycles, 1 redirect, then saturation
    rst_n = 1'b0;
    #1;
    chk("perf_rst_fetch", {16'd0, perf_fetch_cnt}, 32'd0);
    chk("perf_rst_stall", {16'd0, perf_stall_cnt}, 32'd0);
    chk("perf_rst_flush", {16'd0, perf_flush_cnt}, 32'd0);
    push(16'h0000, 16'hC3C3);
    push(16'h0002, 16'hC3C1);
    push(16'h0004, 16'hC3C7);
    push(16'h0100, 16'hC2C3);
    ack_lat    = 0;
    ack_budget = 3;
    cyc();
    rst_n = 1'b1;
    begin
      int k;
      k = 0;
      while (!(if_valid === 1'b1 && if_pc === 16'h0004) && k < 40) begin
        cyc();
        k++;
      end
      chk("perf_reach_pc4", {31'd0, (if_valid === 1'b1 && if_pc === 16'h0004)}, 32'd1);
    end
    stall_in = 1'b1;
    cyc();
    cyc();
    stall_in = 1'b0;
    cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0100;
    cyc();
    redirect_valid = 1'b0;
    chk("perf_fetch3", {16'd0, perf_fetch_cnt}, 32'd3);
    chk("perf_stall2", {16'd0, perf_stall_cnt}, 32'd2);
    chk("perf_flush1", {16'd0, perf_flush_cnt}, 32'd1);
    stall_in   = 1'b1;
    ack_budget = 2;
    repeat (65540) cyc();
    chk("perf_stall_sat", {16'd0, perf_stall_cnt}, 32'h0000FFFF);
    chk("perf_fetch4",    {16'd0, perf_fetch_cnt}, 32'd4);
    stall_in = 1'b0;
    cyc();
    cyc();
    chk("perf_sb_drained", exp_q.size(), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
